data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder.sv | 196 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Purpose : request/response bus between a load/store initiator and the
//           data memory responder.
// Signals : req_valid/req_ready handshake with req_write, req_funct3,
//           req_addr, req_wdata; rsp_valid/rsp_ready handshake with
//           rsp_rdata, rsp_error.
// Modports: master = initiator side, slave = responder side.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose : word-organised data memory answering RISC-V style byte/half/word
//           loads and stores with a fixed response latency.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous active-low reset
//           bus   - data_mem_responder_if.slave (request/response handshake)
// Params  : DEPTH_WORDS - number of 32-bit words
//           LATENCY     - accept-to-rsp_valid cycles, 1..15
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request latched, counting down the latency
// RESP  | response presented, held until rsp_ready
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input logic                  clk,
   input logic                  reset,
   data_mem_responder_if.slave  bus
);
   localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
   localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        r_write;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr, r_wdata;
   logic [31:0] r_rdata;
   logic        r_error;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_accept, w_enter_resp, w_mem_we;
   logic        w_write;
   logic [2:0]  w_funct3;
   logic [31:0] w_addr, w_wdata;
   logic        w_f3_ok, w_misalign, w_oor, w_err;
   logic [AW-1:0] w_idx;
   logic [3:0]  w_be;
   logic [31:0] w_wd, w_word, w_load;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_accept = bus.req_valid && (r_state == IDLE);

   // With LATENCY=1 the accept edge is also the RESP-entry edge, so the
   // request fields must come straight from the bus in that case.
   assign w_write  = (r_state == IDLE) ? bus.req_write  : r_write;
   assign w_funct3 = (r_state == IDLE) ? bus.req_funct3 : r_funct3;
   assign w_addr   = (r_state == IDLE) ? bus.req_addr   : r_addr;
   assign w_wdata  = (r_state == IDLE) ? bus.req_wdata  : r_wdata;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (bus.req_valid) begin
               if (LATENCY == 1) begin
                  w_state_nxt = RESP;
                  w_cnt_nxt   = 4'd0;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = LAT_M1;
               end
            end
         end
         WAIT: begin
            if (r_cnt <= 4'd1) begin
               w_state_nxt = RESP;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);

   always_comb begin
      unique case (w_funct3)
         3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
         3'b100, 3'b101:         w_f3_ok = !w_write;
         default:                w_f3_ok = 1'b0;
      endcase
   end

   assign w_misalign = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                       ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
   assign w_oor      = {2'b00, w_addr[31:2]} >= DEPTH_L;
   assign w_err      = !w_f3_ok || w_misalign || w_oor;
   assign w_idx      = w_addr[AW+1:2];

   always_comb begin
      w_be = 4'b1111;
      w_wd = w_wdata;
      unique case (w_funct3[1:0])
         2'b00: begin
            w_be = 4'b0001 << w_addr[1:0];
            w_wd = {4{w_wdata[7:0]}};
         end
         2'b01: begin
            w_be = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wd = {2{w_wdata[15:0]}};
         end
         default: begin
            w_be = 4'b1111;
            w_wd = w_wdata;
         end
      endcase
   end

   assign w_word = r_mem[w_idx];
   assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_byte = w_word[7:0];
      unique case (w_addr[1:0])
         2'b00: w_byte = w_word[7:0];
         2'b01: w_byte = w_word[15:8];
         2'b10: w_byte = w_word[23:16];
         2'b11: w_byte = w_word[31:24];
         default: w_byte = w_word[7:0];
      endcase
   end

   always_comb begin
      w_load = 32'd0;
      if (!w_err && !w_write) begin
         unique case (w_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
         endcase
      end
   end

   // Gating with reset keeps a store from landing on an edge seen while
   // reset is held, since the array itself is never reset.
   assign w_mem_we = w_enter_resp && w_write && !w_err && reset;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_write  <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_rdata  <= 32'd0;
         r_error  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_write  <= bus.req_write;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
         end
         if (w_enter_resp) begin
            r_rdata <= w_load;
            r_error <= w_err;
         end else if ((r_state == RESP) && bus.rsp_ready) begin
            r_rdata <= 32'd0;
            r_error <= 1'b0;
         end
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_error = r_error;
endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : directed check of data_mem_responder: latency, byte lanes,
//           sign/zero extension, error cases, backpressure and reset
//           behaviour in WAIT and RESP. u_dut2 uses LATENCY=2, u_dut4 LATENCY=4.
module tb_data_mem_responder;
   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                          LBU = 3'b100, LHU = 3'b101;
   localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

   logic clk = 1'b0;
   logic rst2, rst4;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   data_mem_responder_if bus2 ();
   data_mem_responder_if bus4 ();

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
      .clk(clk), .reset(rst2), .bus(bus2));
   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
      .clk(clk), .reset(rst4), .bus(bus4));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drv(input int sel, input logic v, input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d, input logic rr);
      if (sel == 0) begin
         bus2.req_valid = v; bus2.req_write = w; bus2.req_funct3 = f;
         bus2.req_addr = a;  bus2.req_wdata = d; bus2.rsp_ready = rr;
      end else begin
         bus4.req_valid = v; bus4.req_write = w; bus4.req_funct3 = f;
         bus4.req_addr = a;  bus4.req_wdata = d; bus4.rsp_ready = rr;
      end
   endtask

   // which: 0 req_ready, 1 rsp_valid, 2 rsp_rdata, 3 rsp_error
   function automatic logic [31:0] obs(input int sel, input int which);
      if (sel == 0) begin
         case (which)
            0: return {31'd0, bus2.req_ready};
            1: return {31'd0, bus2.rsp_valid};
            2: return bus2.rsp_rdata;
            default: return {31'd0, bus2.rsp_error};
         endcase
      end else begin
         case (which)
            0: return {31'd0, bus4.req_ready};
            1: return {31'd0, bus4.rsp_valid};
            2: return bus4.rsp_rdata;
            default: return {31'd0, bus4.rsp_error};
         endcase
      end
   endfunction

   // Called right after an accept edge (#1 later); returns cycles until rsp_valid.
   task automatic wait_rsp(input int sel, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (obs(sel, 1) == 0 && n < 20);
   endtask

   task automatic txn(input int sel, input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                      output logic [31:0] rd, output logic er);
      int n;
      @(negedge clk);
      drv(sel, 1'b1, w, f, a, d, 1'b0);
      @(posedge clk); #1;
      drv(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      wait_rsp(sel, n);
      chk("latency", n, exp_lat);
      rd = obs(sel, 2);
      er = obs(sel, 3) != 0;
      drv(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      @(posedge clk); #1;
      drv(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic ld(input int sel, input string tag, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_er);
      logic [31:0] rd;
      logic er;
      txn(sel, 1'b0, f, a, 32'd0, (sel == 0) ? 2 : 4, rd, er);
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
   endtask

   task automatic st(input int sel, input string tag, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d, input logic exp_er);
      logic [31:0] rd;
      logic er;
      txn(sel, 1'b1, f, a, d, (sel == 0) ? 2 : 4, rd, er);
      chk({tag, "_rdata"}, rd, 32'd0);
      chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      drv(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      drv(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      rst2 = 1'b0;
      rst4 = 1'b0;
      #22;
      chk("rst_req_ready", obs(0, 0), 32'd1);
      chk("rst_rsp_valid", obs(0, 1), 32'd0);
      chk("rst_rdata",     obs(0, 2), 32'd0);
      chk("rst_err",       obs(0, 3), 32'd0);
      @(negedge clk);
      rst2 = 1'b1;
      rst4 = 1'b1;

      // latency and basic word access
      st(0, "sw10", SW, 32'h10, 32'hDEADBEEF, 1'b0);
      ld(0, "lw10", LW, 32'h10, 32'hDEADBEEF, 1'b0);

      // byte lanes
      st(0, "sw20", SW, 32'h20, 32'h11223344, 1'b0);
      st(0, "sb21", SB, 32'h21, 32'h000000AA, 1'b0);
      ld(0, "lw20a", LW, 32'h20, 32'h1122AA44, 1'b0);
      st(0, "sh22", SH, 32'h22, 32'h0000BEEF, 1'b0);
      ld(0, "lw20b", LW, 32'h20, 32'hBEEFAA44, 1'b0);
      ld(0, "lhu22", LHU, 32'h22, 32'h0000BEEF, 1'b0);
      ld(0, "lh22",  LH,  32'h22, 32'hFFFFBEEF, 1'b0);

      // extension
      st(0, "sw30", SW, 32'h30, 32'h0000F080, 1'b0);
      ld(0, "lb30",  LB,  32'h30, 32'hFFFFFF80, 1'b0);
      ld(0, "lbu30", LBU, 32'h30, 32'h00000080, 1'b0);
      ld(0, "lh30",  LH,  32'h30, 32'hFFFFF080, 1'b0);
      ld(0, "lhu30", LHU, 32'h30, 32'h0000F080, 1'b0);
      ld(0, "lb31",  LB,  32'h31, 32'hFFFFFFF0, 1'b0);
      ld(0, "lbu32", LBU, 32'h32, 32'h00000000, 1'b0);

      // errors leave memory untouched
      st(0, "sw00",  SW, 32'h0, 32'h00000000, 1'b0);
      ld(0, "lw32",  LW, 32'h32, 32'h0, 1'b1);
      st(0, "sh33",  SH, 32'h33, 32'h0000FFFF, 1'b1);
      ld(0, "ld011", 3'b011, 32'h30, 32'h0, 1'b1);
      ld(0, "lw400", LW, 32'h400, 32'h0, 1'b1);
      st(0, "sw400", SW, 32'h400, 32'h12345678, 1'b1);
      st(0, "st100", 3'b100, 32'h30, 32'h00000099, 1'b1);
      st(0, "sw31",  SW, 32'h31, 32'hFFFFFFFF, 1'b1);
      ld(0, "lw30u", LW, 32'h30, 32'h0000F080, 1'b0);
      ld(0, "lw00u", LW, 32'h0, 32'h00000000, 1'b0);
      st(0, "sw3fc", SW, 32'h3FC, 32'hCAFEF00D, 1'b0);
      ld(0, "lw3fc", LW, 32'h3FC, 32'hCAFEF00D, 1'b0);

      // backpressure
      @(negedge clk);
      drv(0, 1'b1, 1'b0, LW, 32'h10, 32'd0, 1'b0);
      @(posedge clk); #1;
      drv(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      wait_rsp(0, n);
      chk("bp_latency", n, 32'd2);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", obs(0, 1), 32'd1);
         chk("bp_rdata", obs(0, 2), 32'hDEADBEEF);
         chk("bp_err",   obs(0, 3), 32'd0);
         chk("bp_ready", obs(0, 0), 32'd0);
         @(negedge clk);
      end
      drv(0, 1'b1, 1'b0, LW, 32'h20, 32'd0, 1'b1);
      @(posedge clk); #1;
      drv(0, 1'b1, 1'b0, LW, 32'h20, 32'd0, 1'b0);
      @(negedge clk);
      chk("bp_hs_valid", obs(0, 1), 32'd0);
      chk("bp_hs_ready", obs(0, 0), 32'd1);
      @(posedge clk); #1;
      drv(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      chk("bp_acc_ready", obs(0, 0), 32'd0);
      n = 1;
      while (obs(0, 1) == 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp2_latency", n, 32'd2);
      chk("bp2_rdata", obs(0, 2), 32'hBEEFAA44);
      drv(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      @(posedge clk); #1;
      drv(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

      // LATENCY=4: reset during WAIT drops the pending store
      st(1, "l4_sw40", SW, 32'h40, 32'h0BADF00D, 1'b0);
      @(negedge clk);
      drv(1, 1'b1, 1'b1, SW, 32'h40, 32'h00000055, 1'b0);
      @(posedge clk); #1;
      drv(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("w4_pre_valid", obs(1, 1), 32'd0);
      chk("w4_pre_ready", obs(1, 0), 32'd0);
      rst4 = 1'b0;
      #1;
      chk("w4_rst_ready", obs(1, 0), 32'd1);
      chk("w4_rst_valid", obs(1, 1), 32'd0);
      chk("w4_rst_rdata", obs(1, 2), 32'd0);
      chk("w4_rst_err",   obs(1, 3), 32'd0);
      @(negedge clk);
      rst4 = 1'b1;
      ld(1, "w4_lw40", LW, 32'h40, 32'h0BADF00D, 1'b0);

      // reset during RESP keeps the committed store
      @(negedge clk);
      drv(1, 1'b1, 1'b1, SW, 32'h44, 32'h00000077, 1'b0);
      @(posedge clk); #1;
      drv(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      wait_rsp(1, n);
      chk("r4_latency", n, 32'd4);
      rst4 = 1'b0;
      #1;
      chk("r4_rst_valid", obs(1, 1), 32'd0);
      chk("r4_rst_ready", obs(1, 0), 32'd1);
      @(negedge clk);
      rst4 = 1'b1;
      ld(1, "r4_lw44", LW, 32'h44, 32'h00000077, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
